// File: rtl/hsiao_pkg.sv
// +----------------------------------------------------------------------------+
// | hsiao_pkg : (13,8) Hsiao SEC-DED constants, encode/syndrome, scrubber FSM  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package hsiao_pkg;

  localparam int CW_W   = 13;
  localparam int DATA_W = 8;
  localparam int CHK_W  = 5;

  // H-matrix columns (s4..s0) for d0..d7; check bit ci uses one-hot(i)
  localparam logic [CHK_W-1:0] COL_D0 = 5'b00111;
  localparam logic [CHK_W-1:0] COL_D1 = 5'b01011;
  localparam logic [CHK_W-1:0] COL_D2 = 5'b01101;
  localparam logic [CHK_W-1:0] COL_D3 = 5'b01110;
  localparam logic [CHK_W-1:0] COL_D4 = 5'b10011;
  localparam logic [CHK_W-1:0] COL_D5 = 5'b10101;
  localparam logic [CHK_W-1:0] COL_D6 = 5'b10110;
  localparam logic [CHK_W-1:0] COL_D7 = 5'b11001;

  localparam logic [DATA_W-1:0][CHK_W-1:0] DATA_COLS =
    {COL_D7, COL_D6, COL_D5, COL_D4, COL_D3, COL_D2, COL_D1, COL_D0};

  function automatic logic [CHK_W-1:0] hsiao_encode(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (d[i]) c = c ^ DATA_COLS[i];
    end
    return c;
  endfunction

  function automatic logic [CHK_W-1:0] hsiao_syndrome(input logic [CW_W-1:0] cw);
    return hsiao_encode(cw[CW_W-1:CHK_W]) ^ cw[CHK_W-1:0];
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hsiao_13_8_decoder.sv
// +----------------------------------------------------------------------------+
// | hsiao_13_8_decoder : combinational (13,8) Hsiao syndrome decode/correct    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module hsiao_13_8_decoder
  import hsiao_pkg::*;
(
  input  logic [CW_W-1:0]  cw,
  output logic [CHK_W-1:0] syndrome,
  output logic             single_err,
  output logic             uncorr_err,
  output logic [CW_W-1:0]  corrected
);

  logic [CW_W-1:0] flip;

  always_comb begin
    syndrome = hsiao_syndrome(cw);
    flip     = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (syndrome == DATA_COLS[i]) flip[CHK_W+i] = 1'b1;
    end
    for (int i = 0; i < CHK_W; i++) begin
      if (syndrome == (CHK_W'(1) << i)) flip[i] = 1'b1;
    end
    // Nonzero syndrome with no matching column covers both even weight and 11010/11100/11111
    single_err = |flip;
    uncorr_err = (syndrome != '0) && !single_err;
    corrected  = cw ^ flip;
  end

endmodule

`default_nettype wire

// File: rtl/mem_hsiao_scrubber.sv
// +----------------------------------------------------------------------------+
// | mem_hsiao_scrubber : background SEC-DED scrubber for a 2**ADDR_W x 13 RAM  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_hsiao_scrubber
  import hsiao_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CW_W-1:0]   mem_wr_data,
  input  logic [CW_W-1:0]   mem_rd_data,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic              ue_valid,
  output logic [ADDR_W-1:0] ue_addr
);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW_W-1:0]   wr_data_q, wr_data_d;
  logic [CW_W-1:0]   rd_word_q, rd_word_d;
  logic [CNT_W-1:0]  corr_q, corr_d;
  logic [CNT_W-1:0]  uncorr_q, uncorr_d;
  logic              ue_valid_q, ue_valid_d;
  logic [ADDR_W-1:0] ue_addr_q, ue_addr_d;

  logic [CHK_W-1:0]  dec_syndrome;
  logic              dec_single;
  logic              dec_uncorr;
  logic [CW_W-1:0]   dec_corrected;

  hsiao_13_8_decoder u_dec (
    .cw         (rd_word_q),
    .syndrome   (dec_syndrome),
    .single_err (dec_single),
    .uncorr_err (dec_uncorr),
    .corrected  (dec_corrected)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    rd_word_d  = rd_word_q;
    corr_d     = corr_q;
    uncorr_d   = uncorr_q;
    ue_valid_d = ue_valid_q;
    ue_addr_d  = ue_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          addr_d     = '0;
          corr_d     = '0;
          uncorr_d   = '0;
          ue_valid_d = 1'b0;
          ue_addr_d  = '0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        rd_word_d = mem_rd_data;
        state_d   = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_NEXT;
        if (dec_syndrome == '0) begin
          state_d = ST_NEXT;
        end else if (dec_single) begin
          wr_data_d = dec_corrected;
          wr_en_d   = 1'b1;
          corr_d    = (corr_q == '1) ? corr_q : corr_q + 1'b1;
          state_d   = ST_WRITE;
        end else if (dec_uncorr) begin
          uncorr_d = (uncorr_q == '1) ? uncorr_q : uncorr_q + 1'b1;
          if (!ue_valid_q) begin
            ue_valid_d = 1'b1;
            ue_addr_d  = addr_q;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (addr_q == '1) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Async clear also kills an in-flight write-back strobe without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      rd_word_q  <= '0;
      corr_q     <= '0;
      uncorr_q   <= '0;
      ue_valid_q <= 1'b0;
      ue_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      rd_word_q  <= rd_word_d;
      corr_q     <= corr_d;
      uncorr_q   <= uncorr_d;
      ue_valid_q <= ue_valid_d;
      ue_addr_q  <= ue_addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wr_data_q;
  assign corr_cnt    = corr_q;
  assign uncorr_cnt  = uncorr_q;
  assign ue_valid    = ue_valid_q;
  assign ue_addr     = ue_addr_q;

endmodule

`default_nettype wire
